// File: rtl/prog_loader.sv
// Program loader: assembles a byte stream into 16-bit instructions (high byte first)
// and writes them to sequential program-memory addresses, holding the CPU in reset until a HLT lands.
module prog_loader #(
  parameter int                DATA_W = 16,
  parameter int                ADDR_W = 11,
  parameter int                OPBTS  = 5,
  parameter logic [OPBTS-1:0]  HLT_OP = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W:0]   o_prog_len,
  output logic              o_cpu_rst
);

  // state     | meaning
  // S_IDLE    | waiting for i_start, stream not consumed
  // S_WAIT_HI | waiting for the high byte of the next instruction
  // S_WAIT_LO | waiting for the low byte
  // S_WRITE   | one-cycle memory write of the assembled word
  // S_DONE    | HLT written, CPU released
  // S_ERROR   | memory filled without a HLT
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_HI, S_WAIT_LO, S_WRITE, S_DONE, S_ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  state_t              r_state, w_state;
  logic [7:0]          r_hi, w_hi;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [ADDR_W:0]     r_prog_len, w_prog_len;
  logic                r_rx_ready, w_rx_ready;
  logic                r_mem_we, w_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr;
  logic [DATA_W-1:0]   r_mem_data, w_mem_data;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic                r_err, w_err;
  logic                r_cpu_rst, w_cpu_rst;
  logic                w_xfer;
  logic [OPBTS-1:0]    w_opcode;

  // r_rx_ready is high exactly in the WAIT states, so it doubles as the handshake qualifier
  assign w_xfer   = r_rx_ready & i_rx_valid;
  assign w_opcode = r_mem_data[DATA_W-1 -: OPBTS];

  always_comb begin
    w_state    = r_state;
    w_hi       = r_hi;
    w_addr     = r_addr;
    w_prog_len = r_prog_len;
    w_mem_we   = 1'b0;
    w_mem_addr = r_mem_addr;
    w_mem_data = r_mem_data;

    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          w_state    = S_WAIT_HI;
          w_addr     = '0;
          w_prog_len = '0;
        end
      end
      S_WAIT_HI: begin
        if (w_xfer) begin
          w_hi    = i_rx_data;
          w_state = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (w_xfer) begin
          w_mem_data = {r_hi, i_rx_data};
          w_mem_addr = r_addr;
          w_mem_we   = 1'b1;
          w_state    = S_WRITE;
        end
      end
      S_WRITE: begin
        w_prog_len = r_prog_len + (ADDR_W+1)'(1);
        if (r_addr != ADDR_LAST) w_addr = r_addr + ADDR_W'(1);
        if (w_opcode == HLT_OP)       w_state = S_DONE;
        else if (r_addr == ADDR_LAST) w_state = S_ERROR;
        else                          w_state = S_WAIT_HI;
      end
      default: w_state = S_IDLE;
    endcase

    // Status outputs are decoded from the next state so they line up with the registered state
    w_rx_ready = (w_state == S_WAIT_HI) || (w_state == S_WAIT_LO);
    w_busy     = (w_state == S_WAIT_HI) || (w_state == S_WAIT_LO) || (w_state == S_WRITE);
    w_done     = (w_state == S_DONE);
    w_err      = (w_state == S_ERROR);
    w_cpu_rst  = (w_state != S_DONE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_hi       <= '0;
      r_addr     <= '0;
      r_prog_len <= '0;
      r_rx_ready <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_cpu_rst  <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_hi       <= w_hi;
      r_addr     <= w_addr;
      r_prog_len <= w_prog_len;
      r_rx_ready <= w_rx_ready;
      r_mem_we   <= w_mem_we;
      r_mem_addr <= w_mem_addr;
      r_mem_data <= w_mem_data;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_err      <= w_err;
      r_cpu_rst  <= w_cpu_rst;
    end
  end

  assign o_rx_ready = r_rx_ready;
  assign o_mem_we   = r_mem_we;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_data = r_mem_data;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_prog_len = r_prog_len;
  assign o_cpu_rst  = r_cpu_rst;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction memory that the control unit's decoder reads.
- Receives a program as a byte stream (from the UART receiver) over a valid/ready handshake and assembles 16-bit instructions, high byte first.
- Writes each instruction to sequential program-memory addresses and stops after the first HLT instruction.
- Holds the CPU in reset for the whole load and releases it once the program is complete.

Parameters:
- DATA_W, 16, instruction width; must equal 2*8.
- ADDR_W, 11, program memory address width.
- OPBTS, 5, opcode field width; opcode is instruction bits [DATA_W-1 : DATA_W-OPBTS].
- HLT_OP, 5'b00000, opcode value that terminates a load.

Ports:
- i_clk, input, 1, system clock; all state changes on the rising edge.
- i_rst, input, 1, reset; asynchronous, active-high.
- i_start, input, 1, starts a load; single-cycle pulse; sampled only in IDLE, DONE and ERROR.
- i_rx_data, input, 8, incoming program byte.
- i_rx_valid, input, 1, i_rx_data is valid.
- o_rx_ready, output, 1, loader can accept a byte; a byte transfers on a rising edge where i_rx_valid and o_rx_ready are both high.
- o_mem_we, output, 1, program memory write strobe; one cycle per instruction.
- o_mem_addr, output, ADDR_W, program memory write address.
- o_mem_data, output, DATA_W, instruction to write.
- o_busy, output, 1, load in progress.
- o_done, output, 1, load completed with a HLT instruction.
- o_err, output, 1, memory filled without a HLT instruction.
- o_prog_len, output, ADDR_W+1, number of words written, HLT included.
- o_cpu_rst, output, 1, CPU reset; high in every state except DONE.

Behaviour:
- States: IDLE, WAIT_HI, WAIT_LO, WRITE, DONE, ERROR.
- All outputs are registered.
- Reset, asynchronous, from any state:
  - state goes to IDLE.
  - o_rx_ready=0, o_mem_we=0, o_mem_addr=0, o_mem_data=0.
  - o_busy=0, o_done=0, o_err=0, o_prog_len=0, o_cpu_rst=1.
  - Memory contents are not touched.
  - A partially received word is discarded.
- IDLE:
  - o_rx_ready=0; incoming bytes are ignored and not consumed.
  - On i_start: clear the address counter and o_prog_len, set o_busy=1, go to WAIT_HI.
- WAIT_HI:
  - o_rx_ready=1.
  - On a transfer: latch the byte into the high half, go to WAIT_LO.
- WAIT_LO:
  - o_rx_ready=1.
  - On a transfer: latch the byte into the low half, go to WRITE.
- WRITE, exactly one cycle:
  - o_rx_ready=0, o_mem_we=1, o_mem_data={hi,lo}, o_mem_addr=current address.
  - On exit: o_prog_len increments and the address increments.
  - If the opcode field equals HLT_OP: go to DONE.
  - Else if the address just written is 2^ADDR_W-1: go to ERROR, and the address does not wrap.
  - Else: go to WAIT_HI.
- Latency: o_mem_we is asserted the cycle after the low-byte transfer. Minimum 3 cycles per word.
- DONE:
  - o_done=1, o_busy=0, o_cpu_rst=0, o_rx_ready=0.
  - o_prog_len holds its value.
- ERROR:
  - o_err=1, o_busy=0, o_cpu_rst=1, o_rx_ready=0.
- From DONE or ERROR:
  - i_start clears o_done, o_err and o_prog_len, and sets o_cpu_rst=1 in the next cycle.
  - The load then restarts at WAIT_HI with address 0.
- i_start while busy (WAIT_HI, WAIT_LO, WRITE) is ignored.
- o_rx_ready depends only on state, never combinationally on i_rx_valid.
- i_rx_valid held high across WRITE: the byte is not consumed until WAIT_HI. No byte is lost or duplicated.
- o_mem_we is never asserted outside WRITE.

Test Plan:
- Reset check: assert i_rst mid-cycle -> all outputs at reset values immediately, without waiting for a clock edge; o_cpu_rst=1.
- Normal load: i_start, then bytes 18 05 20 03 00 00 with valid held high.
  - Writes addr0=0x1805, addr1=0x2003, addr2=0x0000, one o_mem_we cycle each.
  - Then o_done=1, o_prog_len=3, o_cpu_rst=0.
- Backpressure and gaps: random idle cycles on i_rx_valid, valid held across WRITE.
  - Same three memory writes, in order.
  - o_rx_ready=0 in every WRITE cycle; no extra or duplicated words.
- Overflow with ADDR_W=2: send 4 words of 0x2001.
  - Writes to addresses 0..3, then o_err=1 and o_prog_len=4.
  - No fifth write; o_rx_ready stays 0; o_cpu_rst=1.
- Restart: after DONE, pulse i_start and load 0x1807 0x0000.
  - o_done drops and o_cpu_rst rises the next cycle.
  - Writes addr0=0x1807, addr1=0x0000; o_prog_len=2.
- Reset mid-word: assert i_rst after the high byte 0x18 of a load.
  - Returns to IDLE; no write occurs.
  - A new i_start with 20 03 00 00 writes addr0=0x2003, addr1=0x0000.
